// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: tracks in-flight destination registers, selects bypass sources,
// detects load-use stalls and keeps a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned FW      = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic              issue_load,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              src_a_used,
    input  logic [ADDR_W-1:0] src_a,
    input  logic              src_b_used,
    input  logic [ADDR_W-1:0] src_b,
    input  logic              flush,
    output logic [FW-1:0]     fwd_a,
    output logic [FW-1:0]     fwd_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    logic              r_v   [DEPTH];
    logic              r_ld  [DEPTH];
    logic [ADDR_W-1:0] r_rd  [DEPTH];
    logic [CNT_W-1:0]  r_cnt;

    logic [FW-1:0]     w_fwd_a;
    logic [FW-1:0]     w_fwd_b;
    logic              w_haz_a;
    logic              w_haz_b;
    logic              w_stall;
    logic              w_cap_v;

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        w_haz_a = 1'b0;
        w_haz_b = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (r_v[i] && (r_rd[i] == src_a) && (src_a != '0) && src_a_used) begin
                w_fwd_a = FW'(i + 1);
                w_haz_a = r_ld[i] && (i < int'(LOAD_LAT));
            end
            if (r_v[i] && (r_rd[i] == src_b) && (src_b != '0) && src_b_used) begin
                w_fwd_b = FW'(i + 1);
                w_haz_b = r_ld[i] && (i < int'(LOAD_LAT));
            end
        end
    end

    always_comb begin
        w_stall = issue_valid && !flush && (w_haz_a || w_haz_b);
        w_cap_v = issue_valid && issue_we && !w_stall && !flush && (issue_rd != '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_v[i]  <= 1'b0;
                r_ld[i] <= 1'b0;
                r_rd[i] <= '0;
            end
            r_cnt <= '0;
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_v[i]  <= r_v[i-1];
                r_ld[i] <= r_ld[i-1];
                r_rd[i] <= r_rd[i-1];
            end
            // A bubble carries ld=0, rd=0 so retired slots never look live.
            r_v[0]  <= w_cap_v;
            r_ld[0] <= w_cap_v ? issue_load : 1'b0;
            r_rd[0] <= w_cap_v ? issue_rd : '0;
            if (w_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign fwd_a       = w_fwd_a;
    assign fwd_b       = w_fwd_b;
    assign stall       = w_stall;
    assign stall_count = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: bypass selection, load-use stall, flush, reset and
// stall-counter saturation (second instance with a 4-bit counter).
module tb_hazard_scoreboard;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       issue_valid, issue_we, issue_load, flush;
    logic [4:0] issue_rd, src_a, src_b;
    logic       src_a_used, src_b_used;
    logic [1:0] fwd_a, fwd_b, s_fwd_a, s_fwd_b;
    logic       stall, s_stall;
    logic [15:0] stall_count;
    logic [3:0]  s_stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_scoreboard #(.ADDR_W(5), .DEPTH(3), .LOAD_LAT(1), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_load(issue_load), .issue_rd(issue_rd), .src_a_used(src_a_used), .src_a(src_a),
        .src_b_used(src_b_used), .src_b(src_b), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall(stall), .stall_count(stall_count)
    );

    hazard_scoreboard #(.ADDR_W(5), .DEPTH(3), .LOAD_LAT(1), .CNT_W(4)) dut_small (
        .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_load(issue_load), .issue_rd(issue_rd), .src_a_used(src_a_used), .src_a(src_a),
        .src_b_used(src_b_used), .src_b(src_b), .flush(flush), .fwd_a(s_fwd_a),
        .fwd_b(s_fwd_b), .stall(s_stall), .stall_count(s_stall_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a decode slot; all fields explicit to keep vectors readable.
    task automatic drive(input logic v, input logic we, input logic ld, input int rd,
                         input logic au, input int a, input logic bu, input int b,
                         input logic fl);
        issue_valid = v;
        issue_we    = we;
        issue_load  = ld;
        issue_rd    = 5'(rd);
        src_a_used  = au;
        src_a       = 5'(a);
        src_b_used  = bu;
        src_b       = 5'(b);
        flush       = fl;
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (fwd_a !== 2'd0 || fwd_b !== 2'd0 || stall !== 1'b0 || stall_count !== 16'd0)
            $display("FAIL reset_outputs got fa=%0d fb=%0d st=%0d cnt=%0d exp all 0",
                     fwd_a, fwd_b, stall, stall_count);
        else n_pass++;
        // Idle reads of r3 must still see nothing.
        drive(1, 0, 0, 0, 1, 3, 1, 3, 0);
        n_checks++;
        if (fwd_a !== 2'd0 || fwd_b !== 2'd0)
            $display("FAIL reset_idle_fwd got fa=%0d fb=%0d exp 0 0", fwd_a, fwd_b);
        else n_pass++;
        tick();
    endtask

    task automatic test_forward_x();
        idle(3);
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 3, 0, 0, 0);
        n_checks++;
        if (fwd_a !== 2'd1 || stall !== 1'b0)
            $display("FAIL fwd_from_x got fa=%0d st=%0d exp 1 0", fwd_a, stall);
        else n_pass++;
        tick();
    endtask

    task automatic test_forward_age();
        idle(3);
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 3, 0);
        n_checks++;
        if (fwd_b !== 2'd2) $display("FAIL fwd_from_m got %0d exp 2", fwd_b);
        else n_pass++;
        tick();
        n_checks++;
        if (fwd_b !== 2'd3) $display("FAIL fwd_from_w got %0d exp 3", fwd_b);
        else n_pass++;
        tick();
        n_checks++;
        if (fwd_b !== 2'd0) $display("FAIL fwd_retired got %0d exp 0", fwd_b);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        idle(3);
        drive(1, 1, 1, 5, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 5, 0, 0, 0);
        n_checks++;
        if (stall !== 1'b1 || fwd_a !== 2'd1)
            $display("FAIL load_use_stall got st=%0d fa=%0d exp 1 1", stall, fwd_a);
        else n_pass++;
        tick();
        n_checks++;
        if (stall !== 1'b0 || fwd_a !== 2'd2)
            $display("FAIL load_use_release got st=%0d fa=%0d exp 0 2", stall, fwd_a);
        else n_pass++;
        n_checks++;
        if (stall_count !== 16'd1) $display("FAIL load_use_count got %0d exp 1", stall_count);
        else n_pass++;
        tick();
    endtask

    task automatic test_r0_and_youngest();
        idle(3);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 0, 1, 0, 0);
        n_checks++;
        if (fwd_a !== 2'd0 || fwd_b !== 2'd0 || stall !== 1'b0)
            $display("FAIL r0_never_tracked got fa=%0d fb=%0d st=%0d exp 0 0 0",
                     fwd_a, fwd_b, stall);
        else n_pass++;
        tick();
        drive(1, 1, 0, 7, 0, 0, 0, 0, 0);
        tick();
        tick();
        drive(1, 0, 0, 0, 1, 7, 1, 7, 0);
        n_checks++;
        if (fwd_a !== 2'd1) $display("FAIL youngest_wins got %0d exp 1", fwd_a);
        else n_pass++;
        n_checks++;
        if (fwd_b !== 2'd1) $display("FAIL same_src_b got %0d exp 1", fwd_b);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush_and_reset();
        idle(3);
        drive(1, 1, 1, 5, 0, 0, 0, 0, 0);
        tick();
        // Flushed slot is itself a writer of r9; it must not be tracked.
        drive(1, 1, 0, 9, 1, 5, 0, 0, 1);
        n_checks++;
        if (stall !== 1'b0) $display("FAIL flush_kills_stall got %0d exp 0", stall);
        else n_pass++;
        tick();
        drive(1, 0, 0, 0, 1, 5, 1, 9, 0);
        n_checks++;
        if (fwd_b !== 2'd0 || fwd_a !== 2'd2)
            $display("FAIL flush_bubble got fa=%0d fb=%0d exp 2 0", fwd_a, fwd_b);
        else n_pass++;
        n_checks++;
        if (stall_count !== 16'd1) $display("FAIL flush_no_count got %0d exp 1", stall_count);
        else n_pass++;
        tick();
        idle(3);
        drive(1, 1, 0, 4, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 4, 0, 0, 0);
        n_checks++;
        if (fwd_a !== 2'd1) $display("FAIL pre_reset_fwd got %0d exp 1", fwd_a);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (fwd_a !== 2'd0 || stall_count !== 16'd0)
            $display("FAIL async_reset got fa=%0d cnt=%0d exp 0 0", fwd_a, stall_count);
        else n_pass++;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (fwd_a !== 2'd0) $display("FAIL no_stale_fwd got %0d exp 0", fwd_a);
        else n_pass++;
        tick();
    endtask

    task automatic test_saturation();
        idle(3);
        for (int n = 1; n <= 20; n++) begin
            drive(1, 1, 1, 5, 0, 0, 0, 0, 0);
            tick();
            drive(1, 0, 0, 0, 1, 5, 0, 0, 0);
            n_checks++;
            if (stall !== 1'b1) $display("FAIL sat_stall_%0d got %0d exp 1", n, stall);
            else n_pass++;
            tick();
            n_checks++;
            if (s_stall_count !== 4'((n > 15) ? 15 : n))
                $display("FAIL sat_count_%0d got %0d exp %0d", n, s_stall_count,
                         (n > 15) ? 15 : n);
            else n_pass++;
        end
        n_checks++;
        if (stall_count !== 16'd20) $display("FAIL wide_count got %0d exp 20", stall_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_forward_x();
        test_forward_age();
        test_load_use();
        test_r0_and_youngest();
        test_flush_and_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
